// File: rtl/riscv_if_pc_gen.sv
// Purpose: IF-stage program counter with prioritised, stall-buffered redirects and a fetch counter.
// Latency: 1 cycle from fetch ack or applied redirect to the new o_pc / o_flush / o_misaligned.
// Backpressure: i_stall or enable=0 holds the PC; redirects seen then are parked until the stage can move.
module riscv_if_pc_gen #(
  parameter int                    ADDR_WIDTH   = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter bit                    C_EXT        = 1'b1,
  parameter int                    CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  i_stall,
  input  logic                  i_interr,
  input  logic [ADDR_WIDTH-1:0] i_interr_addr,
  input  logic                  i_mret,
  input  logic [ADDR_WIDTH-1:0] i_mret_addr,
  input  logic                  i_jump_branch,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  output logic                  o_fetch_req,
  output logic [ADDR_WIDTH-1:0] o_fetch_addr,
  input  logic                  i_fetch_ack,
  input  logic                  i_fetch_compressed,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_flush,
  output logic                  o_misaligned,
  output logic [CNT_WIDTH-1:0]  o_fetch_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  // Larger encoding wins; PRIO_NONE marks "no redirect this cycle".
  typedef enum logic [1:0] {
    PRIO_NONE   = 2'd0,
    PRIO_JB     = 2'd1,
    PRIO_MRET   = 2'd2,
    PRIO_INTERR = 2'd3
  } prio_t;

  // Clears the low bit (RVC) or the low two bits (RV32/64 base only) of a target.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = C_EXT ? {{(ADDR_WIDTH-1){1'b1}}, 1'b0}
                                                       : {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [ADDR_WIDTH-1:0] STEP_2     = {{(ADDR_WIDTH-2){1'b0}}, 2'b10};
  localparam logic [ADDR_WIDTH-1:0] STEP_4     = {{(ADDR_WIDTH-3){1'b0}}, 3'b100};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic                  pend_valid;
  prio_t                 pend_prio;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic                  flush_r;
  logic                  misaligned_r;
  logic [CNT_WIDTH-1:0]  cnt_r;

  prio_t                 new_prio;
  logic [ADDR_WIDTH-1:0] new_addr;
  logic                  new_vld;
  logic                  new_wins;
  logic                  go;
  logic                  apply;
  logic                  latch;
  logic [ADDR_WIDTH-1:0] apply_addr;
  logic                  apply_misaligned;
  logic                  fetch_req;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] step;

  // Pick this cycle's winning redirect and decide whether it is applied now or parked.
  always_comb begin
    new_prio = PRIO_NONE;
    new_addr = '0;
    if (i_interr) begin
      new_prio = PRIO_INTERR;
      new_addr = i_interr_addr;
    end else if (i_mret) begin
      new_prio = PRIO_MRET;
      new_addr = i_mret_addr;
    end else if (i_jump_branch) begin
      new_prio = PRIO_JB;
      new_addr = i_pc;
    end
    new_vld  = (new_prio != PRIO_NONE);
    // A new redirect displaces the parked one on equal or higher priority.
    new_wins = new_vld && (!pend_valid || (new_prio >= pend_prio));
    go       = enable && !i_stall;
    apply    = go && (new_vld || pend_valid);
    latch    = !go && new_wins;
    apply_addr       = new_wins ? new_addr : pend_addr;
    apply_misaligned = |(apply_addr & ~ALIGN_MASK);
  end

  // Next-state and fetch request; no request while a redirect is parked or a flush is visible.
  always_comb begin
    state_d   = state_q;
    fetch_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = FETCH;
      end
      FETCH: begin
        if (!enable) state_d = IDLE;
        fetch_req = enable && !i_stall && !pend_valid && !flush_r;
      end
      default: state_d = IDLE;
    endcase
  end

  // An ack in a cycle that applies a redirect belongs to the squashed path and is dropped.
  always_comb begin
    xfer = fetch_req && i_fetch_ack && !apply;
    step = (C_EXT && i_fetch_compressed) ? STEP_2 : STEP_4;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // PC register: redirect beats sequential advance.
  always_ff @(posedge clk) begin
    if (reset)     pc_r <= RESET_VECTOR;
    else if (apply) pc_r <= apply_addr & ALIGN_MASK;
    else if (xfer)  pc_r <= pc_r + step;
  end

  // Parked redirect: cleared when any redirect is applied, overwritten by an equal-or-higher one.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_prio  <= PRIO_NONE;
      pend_addr  <= '0;
    end else if (apply) begin
      pend_valid <= 1'b0;
      pend_prio  <= PRIO_NONE;
    end else if (latch) begin
      pend_valid <= 1'b1;
      pend_prio  <= new_prio;
      pend_addr  <= new_addr;
    end
  end

  // One-cycle flush / misaligned pulses following an applied redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_r      <= 1'b0;
      misaligned_r <= 1'b0;
    end else begin
      flush_r      <= apply;
      misaligned_r <= apply && apply_misaligned;
    end
  end

  // Completed-fetch counter, free-running wrap.
  always_ff @(posedge clk) begin
    if (reset)     cnt_r <= '0;
    else if (xfer) cnt_r <= cnt_r + CNT_ONE;
  end

  assign o_fetch_req  = fetch_req;
  assign o_fetch_addr = pc_r;
  assign o_pc         = pc_r;
  assign o_flush      = flush_r;
  assign o_misaligned = misaligned_r;
  assign o_fetch_cnt  = cnt_r;

endmodule

// File: tb/tb_riscv_if_pc_gen.sv
// Directed bench for riscv_if_pc_gen: an RVC instance and a base-ISA instance share all inputs.
// Expected outputs are queued per cycle and popped/compared just after inputs settle.
// Clock period 10; inputs driven and outputs sampled around the falling edge.
module tb_riscv_if_pc_gen;

  logic        clk = 1'b0;
  logic        reset, enable, i_stall;
  logic        i_interr, i_mret, i_jump_branch;
  logic [63:0] i_interr_addr, i_mret_addr, i_pc;
  logic        i_fetch_ack, i_fetch_compressed;

  logic        c_req, c_flush, c_mis;
  logic [63:0] c_addr, c_pc;
  logic [31:0] c_cnt;
  logic        n_req, n_flush, n_mis;
  logic [63:0] n_addr, n_pc;
  logic [31:0] n_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [63:0] pc_c;
    logic [63:0] pc_n;
    logic [31:0] cnt;
    logic        fl;
    logic        mis_c;
    logic        mis_n;
    logic        req;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  riscv_if_pc_gen #(.ADDR_WIDTH(64), .RESET_VECTOR(64'h1000), .C_EXT(1'b1), .CNT_WIDTH(32)) u_c (
    .clk(clk), .reset(reset), .enable(enable), .i_stall(i_stall),
    .i_interr(i_interr), .i_interr_addr(i_interr_addr),
    .i_mret(i_mret), .i_mret_addr(i_mret_addr),
    .i_jump_branch(i_jump_branch), .i_pc(i_pc),
    .o_fetch_req(c_req), .o_fetch_addr(c_addr),
    .i_fetch_ack(i_fetch_ack), .i_fetch_compressed(i_fetch_compressed),
    .o_pc(c_pc), .o_flush(c_flush), .o_misaligned(c_mis), .o_fetch_cnt(c_cnt)
  );

  riscv_if_pc_gen #(.ADDR_WIDTH(64), .RESET_VECTOR(64'h1000), .C_EXT(1'b0), .CNT_WIDTH(32)) u_n (
    .clk(clk), .reset(reset), .enable(enable), .i_stall(i_stall),
    .i_interr(i_interr), .i_interr_addr(i_interr_addr),
    .i_mret(i_mret), .i_mret_addr(i_mret_addr),
    .i_jump_branch(i_jump_branch), .i_pc(i_pc),
    .o_fetch_req(n_req), .o_fetch_addr(n_addr),
    .i_fetch_ack(i_fetch_ack), .i_fetch_compressed(i_fetch_compressed),
    .o_pc(n_pc), .o_flush(n_flush), .o_misaligned(n_mis), .o_fetch_cnt(n_cnt)
  );

  task automatic cmp(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s %s: observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] pc_c, input logic [63:0] pc_n,
                     input logic [31:0] cnt, input logic fl, input logic mis_c,
                     input logic mis_n, input logic req);
    exp_t e;
    e.tag = tag; e.pc_c = pc_c; e.pc_n = pc_n; e.cnt = cnt;
    e.fl = fl; e.mis_c = mis_c; e.mis_n = mis_n; e.req = req;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    cmp(e.tag, "c.pc",    c_pc,           e.pc_c);
    cmp(e.tag, "c.addr",  c_addr,         e.pc_c);
    cmp(e.tag, "c.cnt",   64'(c_cnt),     64'(e.cnt));
    cmp(e.tag, "c.flush", 64'(c_flush),   64'(e.fl));
    cmp(e.tag, "c.mis",   64'(c_mis),     64'(e.mis_c));
    cmp(e.tag, "c.req",   64'(c_req),     64'(e.req));
    cmp(e.tag, "n.pc",    n_pc,           e.pc_n);
    cmp(e.tag, "n.addr",  n_addr,         e.pc_n);
    cmp(e.tag, "n.cnt",   64'(n_cnt),     64'(e.cnt));
    cmp(e.tag, "n.flush", 64'(n_flush),   64'(e.fl));
    cmp(e.tag, "n.mis",   64'(n_mis),     64'(e.mis_n));
    cmp(e.tag, "n.req",   64'(n_req),     64'(e.req));
  endtask

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; i_stall = 1'b0;
    i_interr = 1'b0; i_mret = 1'b0; i_jump_branch = 1'b0;
    i_interr_addr = '0; i_mret_addr = '0; i_pc = '0;
    i_fetch_ack = 1'b0; i_fetch_compressed = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", 64'h1000, 64'h1000, 0, 0, 0, 0, 0);

    // Sequential 4-byte fetches from the reset vector.
    reset = 1'b0; enable = 1'b1; i_fetch_ack = 1'b1; i_fetch_compressed = 1'b0;
    chk("idle", 64'h1000, 64'h1000, 0, 0, 0, 0, 0);
    nxt(); chk("seq0", 64'h1000, 64'h1000, 0, 0, 0, 0, 1);
    nxt(); chk("seq1", 64'h1004, 64'h1004, 1, 0, 0, 0, 1);

    // Jump with a simultaneous ack: ack dropped, flush, no request in flush cycle.
    nxt(); i_jump_branch = 1'b1; i_pc = 64'h3000;
    chk("jb_ack", 64'h1008, 64'h1008, 2, 0, 0, 0, 1);
    nxt(); i_jump_branch = 1'b0;
    chk("jb_flush", 64'h3000, 64'h3000, 2, 1, 0, 0, 0);

    // Jump to 0x3006: legal for RVC, misaligned for base-only.
    nxt(); i_fetch_ack = 1'b0; i_jump_branch = 1'b1; i_pc = 64'h3006;
    chk("jb_post", 64'h3000, 64'h3000, 2, 0, 0, 0, 1);
    nxt(); i_jump_branch = 1'b0;
    chk("misalign", 64'h3006, 64'h3004, 2, 1, 0, 1, 0);

    // Mixed compressed/uncompressed stepping from 0x2000.
    nxt(); i_jump_branch = 1'b1; i_pc = 64'h2000;
    chk("t2_pre", 64'h3006, 64'h3004, 2, 0, 0, 0, 1);
    nxt(); i_jump_branch = 1'b0; i_fetch_ack = 1'b1; i_fetch_compressed = 1'b1;
    chk("t2_flush", 64'h2000, 64'h2000, 2, 1, 0, 0, 0);
    nxt(); chk("t2_a0", 64'h2000, 64'h2000, 2, 0, 0, 0, 1);
    nxt(); i_fetch_compressed = 1'b0;
    chk("t2_a1", 64'h2002, 64'h2004, 3, 0, 0, 0, 1);
    nxt(); i_fetch_compressed = 1'b1;
    chk("t2_a2", 64'h2006, 64'h2008, 4, 0, 0, 0, 1);
    nxt(); i_fetch_ack = 1'b0; i_fetch_compressed = 1'b0;
    chk("t2_end", 64'h2008, 64'h200C, 5, 0, 0, 0, 1);

    // Redirects during stall: interrupt outranks earlier jump and later mret.
    nxt(); i_stall = 1'b1; i_jump_branch = 1'b1; i_pc = 64'h4000;
    chk("t4_a", 64'h2008, 64'h200C, 5, 0, 0, 0, 0);
    nxt(); i_jump_branch = 1'b0; i_interr = 1'b1; i_interr_addr = 64'h8000;
    chk("t4_b", 64'h2008, 64'h200C, 5, 0, 0, 0, 0);
    nxt(); i_interr = 1'b0; i_mret = 1'b1; i_mret_addr = 64'h5000;
    chk("t4_c", 64'h2008, 64'h200C, 5, 0, 0, 0, 0);
    nxt(); i_mret = 1'b0; i_stall = 1'b0;
    chk("t4_release", 64'h2008, 64'h200C, 5, 0, 0, 0, 0);
    nxt(); chk("t4_applied", 64'h8000, 64'h8000, 5, 1, 0, 0, 0);
    nxt(); chk("t4_one_flush", 64'h8000, 64'h8000, 5, 0, 0, 0, 1);

    // Parked mret beats a lower-priority jump arriving as the stall drops.
    nxt(); i_stall = 1'b1; i_mret = 1'b1; i_mret_addr = 64'h5000;
    chk("pw_latch", 64'h8000, 64'h8000, 5, 0, 0, 0, 0);
    nxt(); i_mret = 1'b0; i_stall = 1'b0; i_jump_branch = 1'b1; i_pc = 64'h6000;
    chk("pw_compete", 64'h8000, 64'h8000, 5, 0, 0, 0, 0);
    nxt(); i_jump_branch = 1'b0;
    chk("pw_pend_wins", 64'h5000, 64'h5000, 5, 1, 0, 0, 0);

    // Equal priority: the new redirect replaces the parked one.
    nxt(); i_stall = 1'b1; i_jump_branch = 1'b1; i_pc = 64'h6000;
    chk("tie_latch", 64'h5000, 64'h5000, 5, 0, 0, 0, 0);
    nxt(); i_stall = 1'b0; i_pc = 64'h7000;
    chk("tie_compete", 64'h5000, 64'h5000, 5, 0, 0, 0, 0);
    nxt(); i_jump_branch = 1'b0;
    chk("tie_new_wins", 64'h7000, 64'h7000, 5, 1, 0, 0, 0);

    // Address wrap at the top of the 64-bit space.
    nxt(); i_jump_branch = 1'b1; i_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    chk("wrap_pre", 64'h7000, 64'h7000, 5, 0, 0, 0, 1);
    nxt(); i_jump_branch = 1'b0;
    chk("wrap_flush", 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 5, 1, 0, 0, 0);
    nxt(); i_fetch_ack = 1'b1;
    chk("wrap_ack", 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 5, 0, 0, 0, 1);
    nxt(); i_fetch_ack = 1'b0;
    chk("wrap", 64'h0, 64'h0, 6, 0, 0, 0, 1);

    // Disable: back to IDLE, PC held, no request even with ack high.
    nxt(); enable = 1'b0;
    nxt(); i_fetch_ack = 1'b1;
    chk("dis_hold", 64'h0, 64'h0, 6, 0, 0, 0, 0);

    // Reset while a redirect is parked: everything cleared, no flush afterwards.
    nxt(); enable = 1'b1; i_fetch_ack = 1'b0; i_stall = 1'b1; i_jump_branch = 1'b1; i_pc = 64'h9000;
    chk("rst_stall", 64'h0, 64'h0, 6, 0, 0, 0, 0);
    nxt(); i_jump_branch = 1'b0; reset = 1'b1;
    chk("rst_pend", 64'h0, 64'h0, 6, 0, 0, 0, 0);
    nxt(); reset = 1'b0; i_stall = 1'b0;
    chk("rst_done", 64'h1000, 64'h1000, 0, 0, 0, 0, 0);
    nxt(); chk("rst_no_flush", 64'h1000, 64'h1000, 0, 0, 0, 0, 1);
    nxt(); chk("rst_no_flush2", 64'h1000, 64'h1000, 0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
